// File: rtl/subtractor_if.sv
// subtractor_if: operand/result bundle between a subtractor and its driver
interface subtractor_if;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic [31:0] sum;
  logic        cout;
  modport master (output a, b, cin, input sum, cout);
  modport slave (input a, b, cin, output sum, cout);
endinterface

// File: rtl/subtractor.sv
// subtractor: registered A + ~B + Cin using a two-level 32-bit carry-lookahead adder
module subtractor (
  input logic        clk,
  input logic        rst,
  subtractor_if.slave bus
);
  logic [31:0] b_n, g, p, c, sum_d, sum_q;
  logic [7:0]  gg, pg;
  logic [8:0]  gc;
  logic        cout_d, cout_q;
  function automatic logic all_p(input logic [7:0] pv, input int lo, input int hi);
    logic [7:0] m;
    m = (8'hff << lo) & (8'hff >> (7 - hi));
    return &(pv | ~m);
  endfunction
  assign b_n = ~bus.b;
  assign g   = bus.a & b_n;
  assign p   = bus.a ^ b_n;
  for (genvar i = 0; i < 8; i++) begin : grp
    localparam int L = 4 * i;
    assign gg[i]  = g[L+3] | (p[L+3] & g[L+2]) | (p[L+3] & p[L+2] & g[L+1])
                  | (p[L+3] & p[L+2] & p[L+1] & g[L]);
    assign pg[i]  = &p[L+3:L];
    assign c[L]   = gc[i];
    assign c[L+1] = g[L] | (p[L] & gc[i]);
    assign c[L+2] = g[L+1] | (p[L+1] & g[L]) | (p[L+1] & p[L] & gc[i]);
    assign c[L+3] = g[L+2] | (p[L+2] & g[L+1]) | (p[L+2] & p[L+1] & g[L])
                  | (p[L+2] & p[L+1] & p[L] & gc[i]);
  end
  // each group carry is a flat sum of products over lower groups, not a ripple chain
  always_comb begin
    gc[0] = bus.cin;
    for (int j = 0; j < 8; j++) begin
      gc[j+1] = all_p(pg, 0, j) & bus.cin;
      for (int k = 0; k <= j; k++) gc[j+1] = gc[j+1] | (gg[k] & all_p(pg, k + 1, j));
    end
  end
  assign sum_d  = p ^ c;
  assign cout_d = gc[8];
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_subtractor.sv
// tb_subtractor: directed and random checks of the registered subtractor
module tb_subtractor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  subtractor_if bus ();
  subtractor dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got cout/sum=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic step(input string tag, input logic r, input logic [31:0] a, input logic [31:0] b,
                      input logic ci, input logic ec, input logic [31:0] es);
    @(negedge clk);
    rst = r;
    bus.a = a;
    bus.b = b;
    bus.cin = ci;
    @(posedge clk);
    #1 check(tag, {bus.cout, bus.sum}, {ec, es});
  endtask
  initial begin
    logic [31:0] ra, rb, rs;
    logic        rc, rco;
    step("rst0", 1'b1, 32'h1234_5678, 32'h0000_0001, 1'b1, 1'b0, 32'h0);
    step("rst1", 1'b1, 32'hffff_ffff, 32'h0, 1'b1, 1'b0, 32'h0);
    step("v465", 1'b0, 32'd465, 32'd100, 1'b1, 1'b1, 32'd365);
    step("v895", 1'b0, 32'd895, 32'd100, 1'b0, 1'b1, 32'd794);
    step("v245", 1'b0, 32'd245, 32'd52, 1'b0, 1'b1, 32'd192);
    step("v5", 1'b0, 32'd5, 32'd2, 1'b1, 1'b1, 32'd3);
    step("neg", 1'b0, 32'd800, 32'd5254, 1'b1, 1'b0, 32'hffff_ee9a);
    step("bnd0", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'hffff_ffff);
    step("bnd1", 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0);
    step("bnd2", 1'b0, 32'hffff_ffff, 32'h0, 1'b1, 1'b1, 32'hffff_ffff);
    step("eqb", 1'b0, 32'd7, 32'd7, 1'b0, 1'b0, 32'hffff_ffff);
    step("carry", 1'b0, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7fff_ffff);
    step("pre", 1'b0, 32'd10, 32'd3, 1'b1, 1'b1, 32'd7);
    step("mrst", 1'b1, 32'd99, 32'd1, 1'b1, 1'b0, 32'h0);
    step("post", 1'b0, 32'd20, 32'd4, 1'b1, 1'b1, 32'd16);
    for (int n = 0; n < 10000; n++) begin
      ra = $urandom;
      rb = (n % 8 == 0) ? ra : $urandom;
      rc = 1'($urandom_range(1));
      rs = ra - rb - (rc ? 32'd0 : 32'd1);
      rco = ({1'b0, ra} >= ({1'b0, rb} + (rc ? 33'd0 : 33'd1)));
      step("rand", 1'b0, ra, rb, rc, rco, rs);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
